// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
package lsu_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Request fields held for the duration of one access
  typedef struct packed {
    logic              store;
    size_e             size;
    logic              is_unsigned;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Sign- or zero-extend the low byte/half of a read word
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input size_e             size,
                                                    input logic              is_unsigned);
    logic [DATA_W-1:0] res;
    case (size)
      SZ_BYTE: res = {{24{~is_unsigned & word[7]}}, word[7:0]};
      SZ_HALF: res = {{16{~is_unsigned & word[15]}}, word[15:0]};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the low byte/half of a read word with new store data
  function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_data,
                                                    input size_e             size);
    logic [DATA_W-1:0] res;
    case (size)
      SZ_BYTE: res = {old_word[31:8], new_data[7:0]};
      SZ_HALF: res = {old_word[31:16], new_data[15:0]};
      default: res = new_data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Combinational sign/zero extension of the load result.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  size_e             size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] data_c_o
);

  // Pure function of the captured memory word
  assign data_c_o = load_extend(word_i, size_i, unsigned_i);

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, sub-word stores via read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_read_data
);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;

  size_e       size_c;
  logic        misalign_c;
  logic        req_err_c;
  logic [31:0] ext_c;
  logic [31:0] merge_c;

  // Request screening: misaligned (when enabled) or reserved size completes as an error
  assign size_c     = size_e'(req_size);
  assign misalign_c = ALIGN_CHECK &&
                      (((size_c == SZ_HALF) && req_addr[0]) ||
                       ((size_c == SZ_WORD) && (req_addr[1:0] != 2'b00)));
  assign req_err_c  = misalign_c || (size_c == SZ_RSVD);

  lsu_extend u_extend (
    .word_i     (mem_read_data),
    .size_i     (req_q.size),
    .unsigned_i (req_q.is_unsigned),
    .data_c_o   (ext_c)
  );

  assign merge_c = store_merge(mem_read_data, req_q.wdata, req_q.size);

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    addr_d       = addr_q;
    rdata_d      = rdata_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d            = req_addr;
          req_d.store       = req_store;
          req_d.size        = size_c;
          req_d.is_unsigned = req_unsigned;
          req_d.wdata       = req_wdata;
          if (req_err_c) begin
            state_d      = ST_DONE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else if (!req_store) begin
            state_d = ST_RD;
          end else if (size_c == SZ_WORD) begin
            state_d = ST_WR;
            wdata_d = req_wdata;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (req_q.store) begin
          wdata_d = merge_c;
          state_d = ST_WR;
        end else begin
          rdata_d      = ext_c;
          state_d      = ST_DONE;
          resp_valid_d = 1'b1;
        end
      end
      ST_WR: begin
        state_d      = ST_DONE;
        resp_valid_d = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      addr_q       <= '0;
      rdata_q      <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      rdata_q      <= rdata_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Strobes gated by rst_n so a reset aborts an in-flight write immediately
  assign mem_read       = (state_q == ST_RD) && rst_n;
  assign mem_write      = (state_q == ST_WR) && rst_n;
  assign req_ready      = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: instance 0 has alignment checking, instance 1 does not.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        req_ready_w[2], busy_w[2], resp_valid_w[2], resp_err_w[2];
  logic        mem_read_w[2], mem_write_w[2];
  logic [31:0] resp_rdata_w[2], mem_addr_w[2], mem_wdata_w[2], mem_rdata_w[2];

  logic [7:0]  mem[2][1024];
  logic [7:0]  mod[2][1024];
  logic [31:0] exp_rd[2];

  int          r_lat[2], r_nrd[2], r_nwr[2];
  bit          r_err[2];
  logic [31:0] r_rdata[2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32), .ALIGN_CHECK(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_w[0]),
    .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_w[0]),
    .resp_rdata(resp_rdata_w[0]), .resp_err(resp_err_w[0]), .busy(busy_w[0]),
    .mem_address(mem_addr_w[0]), .mem_write_data(mem_wdata_w[0]),
    .mem_read(mem_read_w[0]), .mem_write(mem_write_w[0]), .mem_read_data(mem_rdata_w[0])
  );

  load_store_unit #(.ADDR_W(32), .ALIGN_CHECK(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_w[1]),
    .req_store(req_store), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid_w[1]),
    .resp_rdata(resp_rdata_w[1]), .resp_err(resp_err_w[1]), .busy(busy_w[1]),
    .mem_address(mem_addr_w[1]), .mem_write_data(mem_wdata_w[1]),
    .mem_read(mem_read_w[1]), .mem_write(mem_write_w[1]), .mem_read_data(mem_rdata_w[1])
  );

  function automatic logic [9:0] ix(input logic [31:0] a);
    return a[9:0];
  endfunction

  // Byte-addressed little-endian memories with combinational read
  for (genvar g = 0; g < 2; g++) begin : g_mem
    assign mem_rdata_w[g] = {mem[g][ix(mem_addr_w[g] + 32'd3)], mem[g][ix(mem_addr_w[g] + 32'd2)],
                             mem[g][ix(mem_addr_w[g] + 32'd1)], mem[g][ix(mem_addr_w[g])]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mod_rd4(input int w, input logic [31:0] a);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) v[8*k +: 8] = mod[w][ix(a + 32'(k))];
    return v;
  endfunction

  // Reference: byte-level behaviour of one request as seen by instance w
  task automatic model(input int w, input bit st, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output bit err, output logic [31:0] ewd,
                       output int enrd, output int enwr);
    int          nb;
    logic [31:0] word;
    logic [31:0] v;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err  = (sz == 2'd3) || ((w == 0) && ((addr % 32'(nb)) != 0));
    ewd  = '0;
    enrd = 0;
    enwr = 0;
    lat  = 1;
    if (err) return;
    if (!st) begin
      word = mod_rd4(w, addr);
      lat  = 2;
      enrd = 1;
      if (nb == 1) begin
        v = word & 32'hFF;
        exp_rd[w] = (!uns && v >= 32'd128) ? v - 32'd256 : v;
      end else if (nb == 2) begin
        v = word & 32'hFFFF;
        exp_rd[w] = (!uns && v >= 32'd32768) ? v - 32'd65536 : v;
      end else begin
        exp_rd[w] = word;
      end
    end else begin
      for (int k = 0; k < nb; k++) mod[w][ix(addr + 32'(k))] = wd[8*k +: 8];
      ewd  = mod_rd4(w, addr);
      enwr = 1;
      enrd = (nb < 4) ? 1 : 0;
      lat  = (nb < 4) ? 3 : 2;
    end
  endtask

  // Issue one request to both instances and check each against the model
  task automatic do_req(input bit st, input logic [1:0] sz, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wd, input bit garble);
    int          e_lat[2], e_nrd[2], e_nwr[2];
    bit          e_err[2];
    logic [31:0] e_wd[2], wd_seen[2];
    bit          done[2];
    for (int w = 0; w < 2; w++) begin
      model(w, st, sz, uns, addr, wd, e_lat[w], e_err[w], e_wd[w], e_nrd[w], e_nwr[w]);
      done[w] = 1'b0; r_nrd[w] = 0; r_nwr[w] = 0; wd_seen[w] = '0;
      r_lat[w] = 0; r_err[w] = 1'b0; r_rdata[w] = '0;
    end
    @(negedge clk);
    chk("req_ready_a", 32'(req_ready_w[0]), 32'd1);
    chk("req_ready_b", 32'(req_ready_w[1]), 32'd1);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(negedge clk);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      for (int w = 0; w < 2; w++) begin
        if (mem_read_w[w] && mem_write_w[w]) chk("strobe_overlap", 32'd1, 32'd0);
        if (mem_read_w[w]) begin
          r_nrd[w]++;
          chk("rd_addr", mem_addr_w[w], addr);
        end
        if (mem_write_w[w]) begin
          r_nwr[w]++;
          wd_seen[w] = mem_wdata_w[w];
          chk("wr_addr", mem_addr_w[w], addr);
          for (int k = 0; k < 4; k++) mem[w][ix(mem_addr_w[w] + 32'(k))] = mem_wdata_w[w][8*k +: 8];
        end
        if (!done[w] && resp_valid_w[w]) begin
          done[w] = 1'b1; r_lat[w] = cyc; r_err[w] = resp_err_w[w]; r_rdata[w] = resp_rdata_w[w];
        end
      end
      if (garble && !done[0] && !done[1]) begin
        req_valid = 1'($urandom); req_store = 1'($urandom); req_size = 2'($urandom);
        req_addr = 32'($urandom_range(0, 1023)); req_wdata = $urandom;
      end else begin
        req_valid = 1'b0;
      end
      if (done[0] && done[1]) break;
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int w = 0; w < 2; w++) begin
      if (!done[w]) begin
        n_tests++; n_fail++;
        $display("FAIL resp_timeout dut%0d: no resp_valid within 8 cycles, required latency %0d", w, e_lat[w]);
      end else begin
        chk($sformatf("latency_%0d", w), 32'(r_lat[w]), 32'(e_lat[w]));
        chk($sformatf("resp_err_%0d", w), 32'(r_err[w]), 32'(e_err[w]));
        chk($sformatf("resp_rdata_%0d", w), r_rdata[w], exp_rd[w]);
      end
      chk($sformatf("n_read_%0d", w), 32'(r_nrd[w]), 32'(e_nrd[w]));
      chk($sformatf("n_write_%0d", w), 32'(r_nwr[w]), 32'(e_nwr[w]));
      if (e_nwr[w] != 0) chk($sformatf("wdata_%0d", w), wd_seen[w], e_wd[w]);
    end
  endtask

  typedef struct {
    bit          st;
    logic [1:0]  sz;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd_a, rd_b;
    bit          err_a, err_b;
    int          lat_a, lat_b, nrd_a, nwr_a;
  } vec_t;

  vec_t vecs[10];

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    for (int w = 0; w < 2; w++) begin
      exp_rd[w] = '0;
      for (int i = 0; i < 1024; i++) begin mem[w][i] = 8'h00; mod[w][i] = 8'h00; end
      mem[w][10'h100] = 8'h80; mem[w][10'h101] = 8'h12; mem[w][10'h102] = 8'h34; mem[w][10'h103] = 8'h56;
      mod[w][10'h100] = 8'h80; mod[w][10'h101] = 8'h12; mod[w][10'h102] = 8'h34; mod[w][10'h103] = 8'h56;
    end

    //            st sz     uns addr          wd            rd_a          rd_b          ea eb la lb nr nw
    vecs[0] = '{0, 2'd0, 0, 32'h100, 32'h0,        32'hFFFFFF80, 32'hFFFFFF80, 0, 0, 2, 2, 1, 0};
    vecs[1] = '{0, 2'd0, 1, 32'h100, 32'h0,        32'h00000080, 32'h00000080, 0, 0, 2, 2, 1, 0};
    vecs[2] = '{0, 2'd1, 0, 32'h100, 32'h0,        32'h00001280, 32'h00001280, 0, 0, 2, 2, 1, 0};
    vecs[3] = '{0, 2'd2, 0, 32'h100, 32'h0,        32'h56341280, 32'h56341280, 0, 0, 2, 2, 1, 0};
    vecs[4] = '{1, 2'd0, 0, 32'h100, 32'hAABBCCDD, 32'h56341280, 32'h56341280, 0, 0, 3, 3, 1, 1};
    vecs[5] = '{0, 2'd2, 0, 32'h100, 32'h0,        32'h563412DD, 32'h563412DD, 0, 0, 2, 2, 1, 0};
    vecs[6] = '{1, 2'd2, 0, 32'h200, 32'hDEADBEEF, 32'h563412DD, 32'h563412DD, 0, 0, 2, 2, 0, 1};
    vecs[7] = '{0, 2'd2, 0, 32'h102, 32'h0,        32'h563412DD, 32'h00005634, 1, 0, 1, 2, 0, 0};
    vecs[8] = '{0, 2'd3, 0, 32'h100, 32'h0,        32'h563412DD, 32'h00005634, 1, 1, 1, 1, 0, 0};
    vecs[9] = '{0, 2'd2, 0, 32'h100, 32'h0,        32'h563412DD, 32'h563412DD, 0, 0, 2, 2, 1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk("rst_ready", 32'(req_ready_w[w]), 32'd1);
      chk("rst_busy", 32'(busy_w[w]), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid_w[w]), 32'd0);
      chk("rst_rdata", resp_rdata_w[w], 32'd0);
      chk("rst_addr", mem_addr_w[w], 32'd0);
      chk("rst_wdata", mem_wdata_w[w], 32'd0);
      chk("rst_strobes", 32'({mem_read_w[w], mem_write_w[w]}), 32'd0);
    end
    rst_n = 1'b1;

    // Directed vectors with hand-derived expectations
    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].st, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, 1'b0);
      chk($sformatf("vec%0d_rdata_a", i), r_rdata[0], vecs[i].rd_a);
      chk($sformatf("vec%0d_rdata_b", i), r_rdata[1], vecs[i].rd_b);
      chk($sformatf("vec%0d_err_a", i), 32'(r_err[0]), 32'(vecs[i].err_a));
      chk($sformatf("vec%0d_err_b", i), 32'(r_err[1]), 32'(vecs[i].err_b));
      chk($sformatf("vec%0d_lat_a", i), 32'(r_lat[0]), 32'(vecs[i].lat_a));
      chk($sformatf("vec%0d_lat_b", i), 32'(r_lat[1]), 32'(vecs[i].lat_b));
      chk($sformatf("vec%0d_nrd_a", i), 32'(r_nrd[0]), 32'(vecs[i].nrd_a));
      chk($sformatf("vec%0d_nwr_a", i), 32'(r_nwr[0]), 32'(vecs[i].nwr_a));
    end
    chk("sw_bytes_200", {mem[0][10'h203], mem[0][10'h202], mem[0][10'h201], mem[0][10'h200]}, 32'hDEADBEEF);

    // Randomized requests, inputs toggled while busy
    for (int n = 0; n < 300; n++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          r;
      r  = $urandom_range(0, 9);
      sz = (r == 0) ? 2'd3 : 2'(r % 3);
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) a = a & ~32'd3;
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, 1'b1);
    end

    // Reset during the write cycle of a halfword store
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'd1; req_unsigned = 1'b0;
    req_addr = 32'h300; req_wdata = 32'h0000BEEF;
    @(negedge clk);
    req_valid = 1'b0;
    for (int w = 0; w < 2; w++) chk("sh_rd_cycle", 32'(mem_read_w[w]), 32'd1);
    @(negedge clk);
    for (int w = 0; w < 2; w++) chk("sh_wr_cycle", 32'(mem_write_w[w]), 32'd1);
    rst_n = 1'b0;
    #1;
    for (int w = 0; w < 2; w++) begin
      chk("abort_mem_write", 32'(mem_write_w[w]), 32'd0);
      if (mem_write_w[w])
        for (int k = 0; k < 4; k++) mem[w][ix(mem_addr_w[w] + 32'(k))] = mem_wdata_w[w][8*k +: 8];
    end
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      chk("abort_ready", 32'(req_ready_w[w]), 32'd1);
      chk("abort_busy", 32'(busy_w[w]), 32'd0);
      chk("abort_rdata", resp_rdata_w[w], 32'd0);
      chk("abort_resp_valid", 32'(resp_valid_w[w]), 32'd0);
      chk("abort_mem_300",
          {mem[w][10'h303], mem[w][10'h302], mem[w][10'h301], mem[w][10'h300]}, mod_rd4(w, 32'h300));
    end
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the data-memory interface. It accepts one load or store request at a time from the execute stage and drives the memory's address, write data, read strobe and write strobe. Loads are sign- or zero-extended. The memory has no byte enables, so sub-word stores are done as a read-modify-write sequence. The block sits between the EX/MEM pipeline register and the data memory, and asserts busy to stall the pipeline.

Parameters:
ADDR_W, 32, width of the byte address driven to memory
ALIGN_CHECK, 1, 1 = reject a misaligned halfword/word access with resp_err and perform no memory access; 0 = pass any byte address through

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request strobe, sampled when req_ready=1
req_ready  out  1  high only in IDLE
req_store  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as an error)
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  in  ADDR_W  effective byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle pulse when the request completes
resp_rdata  out  32  extended load data; holds its value until the next load completes
resp_err  out  1  pulse together with resp_valid for a misaligned or reserved-size request
busy  out  1  high whenever not in IDLE
mem_address  out  ADDR_W  latched request address
mem_write_data  out  32  word to write
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe (level-sensitive at the memory)
mem_read_data  in  32  combinational read data, valid in the same cycle mem_read is high

Behaviour:
- Reset, synchronous on rst_n=0 at a clock edge: state=IDLE; resp_valid=0; resp_err=0; resp_rdata=0; mem_address=0; mem_write_data=0.
- mem_read and mem_write are decoded from the state and ANDed with rst_n, so no strobe is asserted while rst_n is low. A reset during WR therefore aborts the write in that same cycle.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - On req_valid, latch address, size, unsigned flag, store flag and wdata.
  - Error check: if ALIGN_CHECK and ((size=01 and addr[0]) or (size=10 and addr[1:0]!=0)), or size=11 regardless of ALIGN_CHECK, go to DONE with the error flag set and issue no strobe.
  - Otherwise: load -> RD; store word -> WR; store byte/half -> RD.
- RD:
  - Drive mem_read=1; capture mem_read_data at the clock edge.
  - Load: extend the captured word into resp_rdata, then go to DONE.
    - Byte uses bits [7:0], half uses [15:0].
    - Sign bit is bit 7 or bit 15; unsigned zero-fills.
  - Sub-word store: merge into mem_write_data. Byte replaces [7:0] with wdata[7:0]; half replaces [15:0] with wdata[15:0]. Upper bytes keep the values read. Then go to WR.
- WR:
  - Drive mem_write=1 for exactly one cycle.
  - For a word store, mem_write_data = wdata. Then go to DONE.
- DONE: resp_valid=1 (and resp_err if flagged) for one cycle, then go to IDLE.
- Latency from request-accept edge to the resp_valid cycle:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 1 cycle
- Requests are never accepted in DONE; back-to-back throughput is one request per latency+1 cycles.
- mem_read and mem_write are never high in the same cycle.
- mem_address is stable from the first strobe cycle through the last.
- Address wrap: the memory handles addr+1..+3 itself; no wrap logic is required here.
- req_* inputs are ignored while busy.

Decomposition:
- Shared package lsu_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD
  - state encoding
  - functions load_extend(word, size, unsigned) and store_merge(old, new, size)
- One natural sub-module, lsu_extend: combinational sign/zero extension of the load result, instantiated in the RD path.

Test Plan:
- Memory bytes at 0x100 = 0x80,0x12,0x34,0x56; LB 0x100 -> resp_rdata=0xFFFFFF80 two cycles after accept; LBU -> 0x00000080.
- LH 0x100 -> 0x00001280; LW 0x100 -> 0x56341280; no mem_write asserted during either.
- SB 0x100 with wdata=0xAABBCCDD -> RD then WR, mem_write_data=0x563412DD, resp_valid three cycles after accept; a following LW reads 0x563412DD.
- SW 0x200 with wdata=0xDEADBEEF -> no mem_read, one mem_write cycle, bytes at 0x200..0x203 = EF,BE,AD,DE.
- With ALIGN_CHECK=1: LW 0x102 -> resp_valid and resp_err one cycle after accept, zero strobes. With ALIGN_CHECK=0: the same request completes normally. size=11 -> resp_err under both settings.
- Start SH 0x300; assert rst_n=0 in the WR cycle -> mem_write=0 that cycle, memory at 0x300 unchanged, next cycle state IDLE, req_ready=1, resp_rdata=0.
